adc_capture_ctrl: RTL and testbench

//  Triggered capture controller for the ADC1175 datapath. When armed, it waits for a level-crossing

---
 rtl/adc_capture_ctrl.sv | 136 +++++++++++++
 tb/tb_adc_capture_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC capture controller: waits for a level crossing, stores DEPTH decimated
// samples, then streams a 0xA5 header plus the buffer to serial_tx one byte per handshake.
module adc_capture_ctrl #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic [7:0] adc_data,
  input  logic       arm,
  input  logic       abort,
  input  logic       force_trig,
  input  logic [7:0] trig_level,
  input  logic       trig_fall,
  input  logic [3:0] decim,
  input  logic       end_of_send,
  output logic [7:0] sbyte,
  output logic       sbyte_rdy,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_LOAD    = 3'd3,
    ST_REQ     = 3'd4,
    ST_WAIT    = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    mem_q;
  logic [7:0]    prev;
  logic          prev_valid;
  logic [3:0]    decim_r;
  logic [3:0]    dec_cnt;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   rd_idx;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] mem_wa;
  logic          mem_we;
  logic          trig_hit;
  logic          trig_go;
  logic          cap_wr;
  logic          last_wr;
  logic          last_byte;

  always_comb begin
    trig_hit  = '0;
    if (prev_valid) begin
      if (trig_fall) trig_hit = (prev > trig_level) && (adc_data <= trig_level);
      else           trig_hit = (prev < trig_level) && (adc_data >= trig_level);
    end
    trig_go   = (state == ST_ARMED) && (trig_hit || force_trig);
    cap_wr    = (state == ST_CAPTURE) && (dec_cnt == decim_r);
    last_wr   = cap_wr && (wr_addr == AW'(DEPTH - 1));
    last_byte = (rd_idx == (AW+1)'(DEPTH));
    rd_addr   = AW'(rd_idx - 1'b1);
    mem_we    = !abort && (trig_go || cap_wr);
    mem_wa    = (state == ST_ARMED) ? '0 : wr_addr;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (arm) state_nx = ST_ARMED;
      ST_ARMED:   if (trig_go) state_nx = ST_CAPTURE;
      ST_CAPTURE: if (last_wr) state_nx = ST_LOAD;
      ST_LOAD:    state_nx = ST_REQ;
      ST_REQ:     state_nx = ST_WAIT;
      ST_WAIT:    if (end_of_send) state_nx = last_byte ? ST_IDLE : ST_LOAD;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Buffer RAM with registered read port; the read issued in LOAD is consumed in REQ.
  always_ff @(posedge clk12) begin
    if (mem_we) mem[mem_wa] <= adc_data;
    if (state == ST_LOAD) mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      sbyte      <= '0;
      sbyte_rdy  <= '0;
      busy       <= '0;
      done       <= '0;
      prev       <= '0;
      prev_valid <= '0;
      decim_r    <= '0;
      dec_cnt    <= '0;
      wr_addr    <= '0;
      rd_idx     <= '0;
    end else begin
      busy      <= (state_nx != ST_IDLE);
      done      <= (state == ST_WAIT) && end_of_send && last_byte && !abort;
      sbyte_rdy <= (state == ST_REQ) && !abort;
      if ((state == ST_REQ) && !abort) sbyte <= (rd_idx == '0) ? 8'hA5 : mem_q;
      case (state)
        ST_IDLE: if (arm) begin
          decim_r    <= decim;
          prev_valid <= 1'b0;
        end
        ST_ARMED: begin
          prev       <= adc_data;
          prev_valid <= 1'b1;
          if (trig_go) begin
            wr_addr <= AW'(1);
            dec_cnt <= '0;
          end
        end
        ST_CAPTURE: if (cap_wr) begin
          wr_addr <= wr_addr + 1'b1;
          dec_cnt <= '0;
          if (last_wr) rd_idx <= '0;
        end else begin
          dec_cnt <= dec_cnt + 1'b1;
        end
        ST_WAIT: if (end_of_send && !last_byte) rd_idx <= rd_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: records every ARMED/CAPTURE sample and predicts
// the streamed bytes from the trigger and decimation rules.
module tb_adc_capture_ctrl;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic       clk12 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] adc_data = '0;
  logic       arm = 1'b0, abort = 1'b0, force_trig = 1'b0, trig_fall = 1'b0;
  logic [7:0] trig_level = '0;
  logic [3:0] decim = '0;
  logic       eos_auto = 1'b0, eos_man = 1'b0;
  logic       end_of_send;
  logic [7:0] sbyte;
  logic       sbyte_rdy, busy, done;
  logic [2:0] state_o;

  assign end_of_send = eos_auto | eos_man;

  adc_capture_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk12(clk12), .reset(reset), .adc_data(adc_data), .arm(arm), .abort(abort),
    .force_trig(force_trig), .trig_level(trig_level), .trig_fall(trig_fall), .decim(decim),
    .end_of_send(end_of_send), .sbyte(sbyte), .sbyte_rdy(sbyte_rdy), .busy(busy),
    .done(done), .state_o(state_o)
  );

  always #5 clk12 = ~clk12;

  int passes = 0, checks = 0;
  int adc_mode = 0;
  bit rec = 1'b0, auto_on = 1'b0, outstanding = 1'b0;
  logic [7:0] hist[$];
  bit         frc_h[$];
  logic [7:0] stream[$];
  logic [7:0] last_sb = '0;
  int rdy_cnt = 0, done_cnt = 0, resp_n = 0, rsp_delay = 0;
  int cap_hb, cap_sb, cap_db, cap_dec, cap_lvl;
  bit cap_fall;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // One clock: observe outputs at negedge, record samples at posedge, then drive new data.
  task automatic step();
    @(negedge clk12);
    if (reset) begin
      outstanding = 1'b0;
      last_sb = '0;
    end else begin
      if (sbyte_rdy) begin
        chk("one_req_per_eos", outstanding, 0);
        outstanding = 1'b1;
        stream.push_back(sbyte);
        rdy_cnt++;
        last_sb = sbyte;
      end else begin
        chk("sbyte_hold", sbyte, last_sb);
      end
      if (end_of_send || state_o == 3'd0) outstanding = 1'b0;
      if (done) done_cnt++;
    end
    @(posedge clk12);
    if (rec) begin
      hist.push_back(adc_data);
      frc_h.push_back(force_trig);
    end
    #1;
    case (adc_mode)
      1: adc_data = adc_data + 8'd1;
      2: adc_data = adc_data - 8'd1;
      3: adc_data = 8'($urandom_range(0, 255));
      default: ;
    endcase
  endtask

  // serial_tx stand-in: end_of_send 0, 1 or 200 cycles after each request
  always begin
    @(negedge clk12);
    if (auto_on && sbyte_rdy && !reset) begin
      rsp_delay = (resp_n % 40 == 13) ? 200 : ((resp_n % 3 == 1) ? 1 : 0);
      resp_n++;
      @(posedge clk12); #1;
      repeat (rsp_delay) begin @(posedge clk12); #1; end
      eos_auto = 1'b1;
      @(posedge clk12); #1;
      eos_auto = 1'b0;
    end
  end

  task automatic start_capture(input logic [7:0] lvl, input bit fall, input logic [3:0] dec);
    trig_level = lvl; trig_fall = fall; decim = dec;
    cap_lvl = lvl; cap_fall = fall; cap_dec = dec;
    cap_hb = hist.size(); cap_sb = stream.size(); cap_db = done_cnt;
    arm = 1'b1;
    step();
    arm = 1'b0;
    rec = 1'b1;
  endtask

  task automatic finish_capture(input string tag);
    int n, k, idx, p, c;
    n = 0;
    while (done_cnt == cap_db && n < 40000) begin step(); n++; end
    repeat (4) step();
    rec = 1'b0;
    chk({tag, "_done_pulses"}, done_cnt - cap_db, 1);
    chk({tag, "_byte_count"}, stream.size() - cap_sb, DEPTH + 1);
    chk({tag, "_idle"}, state_o, 0);
    k = -1;
    for (int i = 0; i < hist.size() - cap_hb && k < 0; i++) begin
      c = hist[cap_hb + i];
      p = (i > 0) ? hist[cap_hb + i - 1] : 0;
      if (frc_h[cap_hb + i] ||
          (i > 0 && (cap_fall ? (p > cap_lvl && c <= cap_lvl) : (p < cap_lvl && c >= cap_lvl))))
        k = i;
    end
    if (stream.size() > cap_sb) chk({tag, "_header"}, stream[cap_sb], 8'hA5);
    for (int j = 0; j < DEPTH; j++) begin
      idx = cap_hb + k + j * (cap_dec + 1);
      if (k >= 0 && idx < hist.size() && cap_sb + 1 + j < stream.size())
        chk($sformatf("%s_byte%0d", tag, j), stream[cap_sb + 1 + j], hist[idx]);
    end
  endtask

  task automatic abort_now(input string tag);
    int r0, d0;
    abort = 1'b1;
    step();
    abort = 1'b0; eos_man = 1'b0;
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_busy"}, busy, 0);
    r0 = rdy_cnt; d0 = done_cnt;
    repeat (12) step();
    rec = 1'b0;
    chk({tag, "_no_rdy"}, rdy_cnt - r0, 0);
    chk({tag, "_no_done"}, done_cnt - d0, 0);
  endtask

  task automatic wait_first_rdy(input string tag);
    int r0, n;
    r0 = rdy_cnt; n = 0;
    while (rdy_cnt == r0 && n < 3000) begin step(); n++; end
    chk({tag, "_rdy_seen"}, rdy_cnt - r0, 1);
    repeat (3) step();
    chk({tag, "_in_wait"}, state_o, 5);
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", sbyte_rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_sbyte", sbyte, 0);
    reset = 1'b0;
    step();

    // reset in the middle of a capture
    auto_on = 1'b1; adc_mode = 0; adc_data = 8'h10;
    start_capture(8'h80, 1'b0, 4'd0);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    repeat (20) step();
    rec = 1'b0;
    chk("midrst_capturing", state_o, 2);
    #3 reset = 1'b1;
    #1;
    chk("midrst_state", state_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdy", sbyte_rdy, 0);
    step(); step();
    reset = 1'b0;
    step();

    // rising trigger on an up-ramp; arm pulses during CAPTURE and streaming are ignored
    adc_mode = 1; adc_data = 8'h6F;
    start_capture(8'h80, 1'b0, 4'd0);
    repeat (60) step();
    chk("arm_ign_capture_state", state_o, 2);
    arm = 1'b1; step(); arm = 1'b0;
    n = 0;
    while (rdy_cnt - cap_sb < 5 && n < 5000) begin step(); n++; end
    arm = 1'b1; step(); arm = 1'b0;
    finish_capture("rise");
    if (stream.size() > cap_sb + 6) begin
      chk("rise_buf0", stream[cap_sb + 1], 8'h80);
      chk("rise_buf5", stream[cap_sb + 6], 8'h85);
    end

    // falling trigger, decim=3 latched at arm; first ARMED sample sits on the threshold
    adc_mode = 2; adc_data = 8'h41;
    start_capture(8'h40, 1'b1, 4'd3);
    decim = 4'd0;
    repeat (5) step();
    chk("fall_first_no_trig", state_o, 1);
    finish_capture("fall");

    // random data, level, edge and decimation
    for (int it = 0; it < 2; it++) begin
      adc_mode = 3;
      start_capture(8'($urandom_range(40, 215)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
      finish_capture($sformatf("rand%0d", it));
    end

    // force_trig with constant data: capture begins on the first ARMED cycle
    adc_mode = 0; adc_data = 8'h33; force_trig = 1'b1;
    start_capture(8'h80, 1'b0, 4'd1);
    step();
    chk("force_capture_next", state_o, 2);
    force_trig = 1'b0;
    finish_capture("force");

    // aborts
    auto_on = 1'b0; adc_mode = 0; adc_data = 8'h10;
    start_capture(8'h80, 1'b0, 4'd0);
    repeat (3) step();
    chk("abort_armed_pre", state_o, 1);
    abort_now("abort_armed");

    start_capture(8'h80, 1'b0, 4'd0);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    repeat (10) step();
    chk("abort_capture_pre", state_o, 2);
    abort_now("abort_capture");

    start_capture(8'h80, 1'b0, 4'd0);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    wait_first_rdy("abort_wait");
    abort_now("abort_wait");

    start_capture(8'h80, 1'b0, 4'd0);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    wait_first_rdy("abort_eos");
    eos_man = 1'b1;
    abort_now("abort_eos");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
